// File: rtl/autoc_detect_ctrl.sv
// Decision stage for the autocorrelation delay-multiply datapath: windowed
// product accumulation, signed threshold compare, consecutive-hit detection and holdoff.
module autoc_detect_ctrl #(
  parameter int PW = 31,
  parameter int AW = 47
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [15:0]          win_len,
  input  logic signed [AW-1:0] threshold,
  input  logic [3:0]           min_hits,
  input  logic [15:0]          holdoff,
  input  logic signed [PW-1:0] prod_in,
  input  logic                 prod_stb,
  output logic signed [AW-1:0] acc_out,
  output logic                 acc_valid,
  output logic                 detect,
  output logic [1:0]           state_out
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  logic [1:0]           r_state;
  logic signed [AW-1:0] r_acc;
  logic [15:0]          r_wcnt;
  logic [15:0]          r_wlen;
  logic [3:0]           r_hits;
  logic [15:0]          r_hcnt;

  logic signed [AW-1:0] w_sum;
  logic [15:0]          w_wlen_eff;
  logic [3:0]           w_minh;
  logic                 w_last;
  logic                 w_q;
  logic                 w_hit_ok;

  assign w_sum      = r_acc + {{(AW-PW){prod_in[PW-1]}}, prod_in};
  assign w_wlen_eff = (win_len == 16'd0) ? 16'd1 : win_len;
  assign w_minh     = (min_hits == 4'd0) ? 4'd1 : min_hits;
  // 17-bit compare so wcnt+1 cannot wrap for a 65535-product window
  assign w_last     = ({1'b0, r_wcnt} + 17'd1) == {1'b0, r_wlen};
  assign w_q        = w_sum >= threshold;
  assign w_hit_ok   = ({1'b0, r_hits} + 5'd1) >= {1'b0, w_minh};
  assign state_out  = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_wcnt    <= '0;
      r_wlen    <= '0;
      r_hits    <= '0;
      r_hcnt    <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      detect    <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      detect    <= 1'b0;
      if (!enable) begin
        r_state <= S_IDLE;
        r_acc   <= '0;
        r_wcnt  <= '0;
        r_hits  <= '0;
        r_hcnt  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_SEARCH;
            r_wlen  <= w_wlen_eff;
            r_acc   <= '0;
            r_wcnt  <= '0;
            r_hits  <= '0;
          end
          S_SEARCH: begin
            if (prod_stb) begin
              if (w_last) begin
                acc_out   <= w_sum;
                acc_valid <= 1'b1;
                r_acc     <= '0;
                r_wcnt    <= '0;
                r_wlen    <= w_wlen_eff;
                if (w_q && w_hit_ok) begin
                  detect  <= 1'b1;
                  r_hits  <= '0;
                  r_hcnt  <= holdoff;
                  r_state <= S_HOLD;
                end else if (w_q) begin
                  r_hits <= (r_hits == 4'd15) ? 4'd15 : r_hits + 4'd1;
                end else begin
                  r_hits <= '0;
                end
              end else begin
                r_acc  <= w_sum;
                r_wcnt <= r_wcnt + 16'd1;
              end
            end
          end
          S_HOLD: begin
            r_acc  <= '0;
            r_wcnt <= '0;
            if (r_hcnt == 16'd0) begin
              r_state <= S_SEARCH;
              r_wlen  <= w_wlen_eff;
            end else begin
              r_hcnt <= r_hcnt - 16'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
